// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared opcodes, register/ALU control codes and control-unit
//            state encodings for the 4-bit CPU.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Opcodes delivered by the instruction memory
    localparam logic [2:0] OP_CARREGA_X = 3'b000;
    localparam logic [2:0] OP_SOMA      = 3'b001;
    localparam logic [2:0] OP_SUBTRAI   = 3'b010;
    localparam logic [2:0] OP_E         = 3'b011;
    localparam logic [2:0] OP_OU        = 3'b100;
    localparam logic [2:0] OP_MOVE_Z    = 3'b101;
    localparam logic [2:0] OP_LIMPA     = 3'b110;
    localparam logic [2:0] OP_HALT      = 3'b111;

    // Register control codes; remaining values are reserved
    localparam logic [3:0] REG_HOLD  = 4'b0000;
    localparam logic [3:0] REG_LOAD  = 4'b0001;
    localparam logic [3:0] REG_CLEAR = 4'b0010;

    // ALU operation select
    localparam logic [3:0] ULA_ADD   = 4'b0000;
    localparam logic [3:0] ULA_SUB   = 4'b0001;
    localparam logic [3:0] ULA_AND   = 4'b0010;
    localparam logic [3:0] ULA_OR    = 4'b0011;
    localparam logic [3:0] ULA_NOTX  = 4'b0100;
    localparam logic [3:0] ULA_PASSX = 4'b0101;

    // Control-unit states; encodings are visible on the debug port
    typedef enum logic [2:0] {
        OCIOSO     = 3'b000,
        BUSCA      = 3'b001,
        DECODIFICA = 3'b010,
        EXECUTA    = 3'b011,
        AVANCA     = 3'b100,
        PARADO     = 3'b101
    } estado_t;

endpackage
`default_nettype wire

// File: rtl/unidade_controle_decodificador_op.sv
`default_nettype none
// ============================================================================
// Module   : decodificador_op
// Brief    : Combinational opcode decoder, maps an opcode to the register
//            control codes and ALU select used during EXECUTA.
// Revision : 1.0 - initial release
// ============================================================================
module decodificador_op
    import cpu_pkg::*;
(
    input  logic [2:0] op_i,
    output logic [3:0] tx_o,
    output logic [3:0] ty_o,
    output logic [3:0] tz_o,
    output logic [3:0] tula_o
);

    // Opcode to control-code table; HALT leaves everything at HOLD/ADD
    always_comb begin
        tx_o   = REG_HOLD;
        ty_o   = REG_HOLD;
        tz_o   = REG_HOLD;
        tula_o = ULA_ADD;
        case (op_i)
            OP_CARREGA_X: tx_o = REG_LOAD;
            OP_SOMA: begin
                tula_o = ULA_ADD;
                ty_o   = REG_LOAD;
            end
            OP_SUBTRAI: begin
                tula_o = ULA_SUB;
                ty_o   = REG_LOAD;
            end
            OP_E: begin
                tula_o = ULA_AND;
                ty_o   = REG_LOAD;
            end
            OP_OU: begin
                tula_o = ULA_OR;
                ty_o   = REG_LOAD;
            end
            OP_MOVE_Z: tz_o = REG_LOAD;
            OP_LIMPA: begin
                tx_o = REG_CLEAR;
                ty_o = REG_CLEAR;
                tz_o = REG_CLEAR;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/unidade_controle.sv
`default_nettype none
// ============================================================================
// Module   : unidade_controle
// Brief    : Multi-cycle control unit: fetch/decode/execute/advance FSM with
//            registered (Moore) control outputs, halt handling and a
//            saturating retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module unidade_controle
    import cpu_pkg::*;
#(
    parameter int LARGURA_CONT = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    inicia,
    input  logic [2:0]              instrucao,
    input  logic                    rco,
    output logic [3:0]              tx,
    output logic [3:0]              ty,
    output logic [3:0]              tz,
    output logic [3:0]              tula,
    output logic                    pc_avanca,
    output logic                    parado,
    output logic [2:0]              estado,
    output logic [LARGURA_CONT-1:0] contagem_instr
);

    localparam logic [LARGURA_CONT-1:0] CONT_UM  = {{(LARGURA_CONT-1){1'b0}}, 1'b1};
    localparam logic [LARGURA_CONT-1:0] CONT_MAX = {LARGURA_CONT{1'b1}};

    estado_t                 estado_q, estado_d;
    logic [2:0]              ir_q, ir_d;
    logic [3:0]              tx_q, tx_d, ty_q, ty_d, tz_q, tz_d, tula_q, tula_d;
    logic                    pc_avanca_q, pc_avanca_d;
    logic                    parado_q, parado_d;
    logic [LARGURA_CONT-1:0] cont_q, cont_d;
    logic [3:0]              dec_tx, dec_ty, dec_tz, dec_tula;

    // Decodes the opcode that ir will hold next, so the codes can be
    // registered on the same edge that enters EXECUTA.
    decodificador_op u_decodificador_op (
        .op_i   (ir_d),
        .tx_o   (dec_tx),
        .ty_o   (dec_ty),
        .tz_o   (dec_tz),
        .tula_o (dec_tula)
    );

    // Next-state, instruction latch, counter and next-output logic
    always_comb begin
        estado_d = estado_q;
        ir_d     = ir_q;
        cont_d   = cont_q;
        case (estado_q)
            OCIOSO:     if (inicia) estado_d = BUSCA;
            BUSCA:      estado_d = DECODIFICA;
            DECODIFICA: begin
                ir_d     = instrucao;
                estado_d = (instrucao == OP_HALT) ? PARADO : EXECUTA;
            end
            EXECUTA:    estado_d = AVANCA;
            AVANCA: begin
                // Instruction retires on the edge that leaves AVANCA
                if (cont_q != CONT_MAX) cont_d = cont_q + CONT_UM;
                estado_d = rco ? PARADO : BUSCA;
            end
            PARADO:     estado_d = PARADO;
            default:    estado_d = OCIOSO;
        endcase

        // Outputs are registered against the state being entered
        tx_d        = (estado_d == EXECUTA) ? dec_tx   : REG_HOLD;
        ty_d        = (estado_d == EXECUTA) ? dec_ty   : REG_HOLD;
        tz_d        = (estado_d == EXECUTA) ? dec_tz   : REG_HOLD;
        tula_d      = (estado_d == EXECUTA) ? dec_tula : ULA_ADD;
        pc_avanca_d = (estado_d == AVANCA);
        parado_d    = (estado_d == PARADO);
    end

    // State and output registers; reset overrides every transition
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            ir_q        <= OP_CARREGA_X;
            tx_q        <= REG_HOLD;
            ty_q        <= REG_HOLD;
            tz_q        <= REG_HOLD;
            tula_q      <= ULA_ADD;
            pc_avanca_q <= 1'b0;
            parado_q    <= 1'b0;
            cont_q      <= '0;
        end else begin
            estado_q    <= estado_d;
            ir_q        <= ir_d;
            tx_q        <= tx_d;
            ty_q        <= ty_d;
            tz_q        <= tz_d;
            tula_q      <= tula_d;
            pc_avanca_q <= pc_avanca_d;
            parado_q    <= parado_d;
            cont_q      <= cont_d;
        end
    end

    assign tx             = tx_q;
    assign ty             = ty_q;
    assign tz             = tz_q;
    assign tula           = tula_q;
    assign pc_avanca      = pc_avanca_q;
    assign parado         = parado_q;
    assign estado         = estado_q;
    assign contagem_instr = cont_q;

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle.sv
`default_nettype none
// ============================================================================
// Module   : tb_unidade_controle
// Brief    : Self-checking bench for unidade_controle (default width and a
//            2-bit counter instance driven in parallel).
// Revision : 1.0 - initial release
// ============================================================================
module tb_unidade_controle;

    typedef logic [2:0] op_t;

    typedef struct {
        logic        ini;
        logic [2:0]  ins;
        logic        rco;
        logic [51:0] exp;
    } step_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic inicia = 1'b0;
    logic [2:0] instrucao = 3'b000;
    logic rco = 1'b0;

    logic [3:0] tx, ty, tz, tula, tx2, ty2, tz2, tula2;
    logic       pc_avanca, parado, pc_avanca2, parado2;
    logic [2:0] estado, estado2;
    logic [7:0] contagem_instr;
    logic [1:0] contagem2;

    int total = 0;
    int bad   = 0;

    step_t       tr[$];
    logic [51:0] obs[$];
    op_t         prog_q[$];

    always #5 clock = ~clock;

    unidade_controle #(.LARGURA_CONT(8)) dut (
        .clock(clock), .reset(reset), .inicia(inicia), .instrucao(instrucao), .rco(rco),
        .tx(tx), .ty(ty), .tz(tz), .tula(tula), .pc_avanca(pc_avanca),
        .parado(parado), .estado(estado), .contagem_instr(contagem_instr)
    );

    unidade_controle #(.LARGURA_CONT(2)) dut2 (
        .clock(clock), .reset(reset), .inicia(inicia), .instrucao(instrucao), .rco(rco),
        .tx(tx2), .ty(ty2), .tz(tz2), .tula(tula2), .pc_avanca(pc_avanca2),
        .parado(parado2), .estado(estado2), .contagem_instr(contagem2)
    );

    // Expected {tx,ty,tz,tula} during EXECUTA for each opcode
    function automatic logic [15:0] exp_codes(input op_t op);
        case (op)
            3'd0:    return 16'h1000;
            3'd1:    return 16'h0100;
            3'd2:    return 16'h0101;
            3'd3:    return 16'h0102;
            3'd4:    return 16'h0103;
            3'd5:    return 16'h0010;
            3'd6:    return 16'h2220;
            default: return 16'h0000;
        endcase
    endfunction

    // Packs expectations for both instances; count saturates per width
    function automatic logic [51:0] pk(input logic [2:0] st, input logic [15:0] c,
                                       input logic pa, input logic pr, input int cnt);
        logic [7:0] c8;
        logic [1:0] c2;
        c8 = (cnt > 255) ? 8'hFF : 8'(cnt);
        c2 = (cnt > 3)   ? 2'd3  : 2'(cnt);
        return {st, c, pa, pr, c8, st, c, pa, pr, c2};
    endfunction

    function automatic logic [51:0] sample();
        return {estado, tx, ty, tz, tula, pc_avanca, parado, contagem_instr,
                estado2, tx2, ty2, tz2, tula2, pc_avanca2, parado2, contagem2};
    endfunction

    function automatic void add(input logic ini, input logic [2:0] ins,
                                input logic r, input logic [51:0] e);
        step_t s;
        s.ini = ini; s.ins = ins; s.rco = r; s.exp = e;
        tr.push_back(s);
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] ro();
        return 3'($urandom_range(0, 7));
    endfunction

    // Instruction-level reference: each non-HALT instruction is four cycles,
    // HALT stops after decode, rco in the advance cycle of rco_at stops.
    function automatic void build(input int rco_at);
        int cnt;
        op_t op;
        cnt = 0;
        tr.delete();
        add(1'b0, ro(), rb(), pk(3'd0, 16'h0, 1'b0, 1'b0, 0));
        add(1'b0, ro(), rb(), pk(3'd0, 16'h0, 1'b0, 1'b0, 0));
        add(1'b1, ro(), rb(), pk(3'd0, 16'h0, 1'b0, 1'b0, 0));
        for (int k = 0; k < prog_q.size(); k++) begin
            op = prog_q[k];
            add(rb(), ro(), rb(), pk(3'd1, 16'h0, 1'b0, 1'b0, cnt));
            add(rb(), op,   rb(), pk(3'd2, 16'h0, 1'b0, 1'b0, cnt));
            if (op == 3'd7) break;
            add(rb(), ro(), rb(), pk(3'd3, exp_codes(op), 1'b0, 1'b0, cnt));
            add(rb(), ro(), (k == rco_at), pk(3'd4, 16'h0, 1'b1, 1'b0, cnt));
            cnt++;
            if (k == rco_at) break;
        end
        for (int j = 0; j < 10; j++)
            add(1'b1, ro(), rb(), pk(3'd5, 16'h0, 1'b0, 1'b1, cnt));
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; inicia = 1'b0; rco = 1'b0; instrucao = 3'b000;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic play();
        obs.delete();
        foreach (tr[i]) begin
            @(negedge clock);
            obs.push_back(sample());
            inicia = tr[i].ini; instrucao = tr[i].ins; rco = tr[i].rco;
        end
    endtask

    task automatic test_reset();
        logic [51:0] got;
        do_reset();
        got = sample();
        total++;
        if (got !== pk(3'd0, 16'h0, 1'b0, 1'b0, 0)) begin
            bad++;
            $display("FAIL reset_values: got %h want %h", got, pk(3'd0, 16'h0, 1'b0, 1'b0, 0));
        end
    endtask

    task automatic test_single();
        do_reset();
        prog_q = '{3'd0, 3'd7};
        build(0);
        play();
        foreach (tr[i]) begin
            total++;
            if (obs[i] !== tr[i].exp) begin
                bad++;
                $display("FAIL single step %0d: got %h want %h", i, obs[i], tr[i].exp);
            end
        end
    endtask

    task automatic test_program();
        do_reset();
        prog_q = '{3'd0, 3'd1, 3'd5, 3'd7};
        build(-1);
        play();
        foreach (tr[i]) begin
            total++;
            if (obs[i] !== tr[i].exp) begin
                bad++;
                $display("FAIL program step %0d: got %h want %h", i, obs[i], tr[i].exp);
            end
        end
    endtask

    task automatic test_rco_end();
        do_reset();
        prog_q = '{3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
        build(1);
        play();
        foreach (tr[i]) begin
            total++;
            if (obs[i] !== tr[i].exp) begin
                bad++;
                $display("FAIL rco_end step %0d: got %h want %h", i, obs[i], tr[i].exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [51:0] got;
        do_reset();
        @(negedge clock); inicia = 1'b1;
        @(negedge clock); inicia = 1'b0; instrucao = ro();
        @(negedge clock); instrucao = 3'd0;
        @(negedge clock); instrucao = ro();
        @(negedge clock); rco = 1'b0;
        @(negedge clock); instrucao = ro();
        @(negedge clock); instrucao = 3'd6;
        @(negedge clock);
        got = sample();
        total++;
        if (got !== pk(3'd3, 16'h2220, 1'b0, 1'b0, 1)) begin
            bad++;
            $display("FAIL limpa_execute: got %h want %h", got, pk(3'd3, 16'h2220, 1'b0, 1'b0, 1));
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        got = sample();
        total++;
        if (got !== pk(3'd0, 16'h0, 1'b0, 1'b0, 0)) begin
            bad++;
            $display("FAIL reset_in_execute: got %h want %h", got, pk(3'd0, 16'h0, 1'b0, 1'b0, 0));
        end
    endtask

    task automatic test_random();
        int n, at;
        for (int t = 0; t < 8; t++) begin
            do_reset();
            prog_q.delete();
            n = $urandom_range(1, 10);
            for (int k = 0; k < n; k++) prog_q.push_back(ro());
            prog_q.push_back(3'd7);
            at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            build(at);
            play();
            foreach (tr[i]) begin
                total++;
                if (obs[i] !== tr[i].exp) begin
                    bad++;
                    $display("FAIL random run %0d step %0d: got %h want %h", t, i, obs[i], tr[i].exp);
                end
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        prog_q.delete();
        for (int k = 0; k < 258; k++) prog_q.push_back(3'd1);
        prog_q.push_back(3'd7);
        build(-1);
        play();
        foreach (tr[i]) begin
            total++;
            if (obs[i] !== tr[i].exp) begin
                bad++;
                $display("FAIL saturation step %0d: got %h want %h", i, obs[i], tr[i].exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_program();
        test_rco_end();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
